// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the MEM-stage
// load/store port (p0, fixed priority) and a debug/DMA master (p1).
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   pX_req/we/addr/wdata/be_i          requester access (held until gnt)
//   pX_gnt/rvalid/err/rdata_o          requester handshake and response
//   mem_req/we/addr/wdata/be_o         memory request channel
//   mem_gnt/rvalid/rdata_i             memory accept and response
//   busy_o                             an access is in flight
//
// At most one transaction is outstanding. p1 wins after MAX_WAIT
// consecutive losses. An unanswered response aborts after TIMEOUT
// RESP cycles with rvalid+err.

module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic [3:0]  p0_be_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    output logic        p0_err_o,
    output logic [31:0] p0_rdata_o,

    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    input  logic [3:0]  p1_be_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic        p1_err_o,
    output logic [31:0] p1_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;
    logic        owner;
    logic [3:0]  wait_cnt;
    logic [7:0]  tmo_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        p1_wins;
    logic        tmo_hit;
    logic        done;
    logic        gnt;
    logic [31:0] rdata;

    assign p1_wins = p1_req_i &&
                     (!p0_req_i || wait_cnt == 4'(MAX_WAIT));

    // A real response in the last allowed cycle beats the timeout.
    assign tmo_hit = (state == RESP) && !mem_rvalid_i &&
                     (tmo_cnt == 8'(TIMEOUT - 1));

    assign done  = (state == RESP) && (mem_rvalid_i || tmo_hit);
    assign gnt   = (state == REQ) && mem_gnt_i;
    assign rdata = ((state == RESP) && mem_rvalid_i) ?
                   mem_rdata_i : 32'h0;

    assign p0_gnt_o    = gnt && !owner;
    assign p1_gnt_o    = gnt && owner;
    assign p0_rvalid_o = done && !owner;
    assign p1_rvalid_o = done && owner;
    assign p0_err_o    = tmo_hit && !owner;
    assign p1_err_o    = tmo_hit && owner;
    assign p0_rdata_o  = owner ? 32'h0 : rdata;
    assign p1_rdata_o  = owner ? rdata : 32'h0;

    assign mem_req_o   = (state == REQ);
    assign mem_we_o    = lat_we;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;
    assign mem_be_o    = lat_be;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            owner     <= 1'b0;
            wait_cnt  <= 4'd0;
            tmo_cnt   <= 8'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p0_req_i || p1_req_i) begin
                        state <= REQ;
                        owner <= p1_wins;
                        if (p1_wins) begin
                            lat_we    <= p1_we_i;
                            lat_addr  <= p1_addr_i;
                            lat_wdata <= p1_wdata_i;
                            lat_be    <= p1_be_i;
                            wait_cnt  <= 4'd0;
                        end else begin
                            lat_we    <= p0_we_i;
                            lat_addr  <= p0_addr_i;
                            lat_wdata <= p0_wdata_i;
                            lat_be    <= p0_be_i;
                            if (p1_req_i &&
                                wait_cnt != 4'(MAX_WAIT))
                                wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state   <= RESP;
                        tmo_cnt <= 8'd0;
                    end
                end
                RESP: begin
                    if (done)
                        state <= IDLE;
                    else
                        tmo_cnt <= tmo_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-step bench for dmem_arbiter.
// Inputs change 1ns after posedge; outputs are checked at negedge.

module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        p0_req_i, p0_we_i;
    logic [31:0] p0_addr_i, p0_wdata_i;
    logic [3:0]  p0_be_i;
    logic        p0_gnt_o, p0_rvalid_o, p0_err_o;
    logic [31:0] p0_rdata_o;
    logic        p1_req_i, p1_we_i;
    logic [31:0] p1_addr_i, p1_wdata_i;
    logic [3:0]  p1_be_i;
    logic        p1_gnt_o, p1_rvalid_o, p1_err_o;
    logic [31:0] p1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic exp_own [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    dmem_arbiter #(.MAX_WAIT(4), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i),
        .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
        .p0_be_i(p0_be_i), .p0_gnt_o(p0_gnt_o),
        .p0_rvalid_o(p0_rvalid_o), .p0_err_o(p0_err_o),
        .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i),
        .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
        .p1_be_i(p1_be_i), .p1_gnt_o(p1_gnt_o),
        .p1_rvalid_o(p1_rvalid_o), .p1_err_o(p1_err_o),
        .p1_rdata_o(p1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_p0_gnt"}, 32'(p0_gnt_o), 32'h0);
        chk({tag, "_p0_rv"}, 32'(p0_rvalid_o), 32'h0);
        chk({tag, "_p1_gnt"}, 32'(p1_gnt_o), 32'h0);
        chk({tag, "_p1_rv"}, 32'(p1_rvalid_o), 32'h0);
    endtask

    initial begin
        rst_ni = 1'b0;
        p0_req_i = 0; p0_we_i = 0; p0_addr_i = 0;
        p0_wdata_i = 0; p0_be_i = 0;
        p1_req_i = 0; p1_we_i = 0; p1_addr_i = 0;
        p1_wdata_i = 0; p1_be_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;

        // reset state
        repeat (2) @(posedge clk_i);
        mid();
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_mreq", 32'(mem_req_o), 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk_quiet("rst");
        nxt();
        rst_ni = 1'b1;

        // single p0 load
        nxt();
        p0_req_i = 1; p0_addr_i = 32'h4; p0_be_i = 4'hf;
        mid();
        chk("ld_idle_busy", 32'(busy_o), 32'h0);
        nxt();
        mem_gnt_i = 1;
        mid();
        chk("ld_mreq", 32'(mem_req_o), 32'h1);
        chk("ld_addr", mem_addr_o, 32'h4);
        chk("ld_we", 32'(mem_we_o), 32'h0);
        chk("ld_p0_gnt", 32'(p0_gnt_o), 32'h1);
        chk("ld_p1_gnt", 32'(p1_gnt_o), 32'h0);
        nxt();
        p0_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        mid();
        chk("ld_mreq_resp", 32'(mem_req_o), 32'h0);
        chk("ld_p0_rv", 32'(p0_rvalid_o), 32'h1);
        chk("ld_p0_rdata", p0_rdata_o, 32'hDEADBEEF);
        chk("ld_p0_err", 32'(p0_err_o), 32'h0);
        chk("ld_p1_rv", 32'(p1_rvalid_o), 32'h0);
        chk("ld_p1_rdata", p1_rdata_o, 32'h0);
        nxt();
        mem_rvalid_i = 0;
        mid();
        chk("ld_done_busy", 32'(busy_o), 32'h0);

        // p1 store with a 2-cycle grant stall
        nxt();
        p1_req_i = 1; p1_we_i = 1; p1_addr_i = 32'h8;
        p1_wdata_i = 32'h1234; p1_be_i = 4'b0011;
        nxt();
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("st_mreq", 32'(mem_req_o), 32'h1);
            chk("st_addr", mem_addr_o, 32'h8);
            chk("st_we", 32'(mem_we_o), 32'h1);
            chk("st_be", 32'(mem_be_o), 32'h3);
            chk("st_wdata", mem_wdata_o, 32'h1234);
            chk("st_p1_gnt_stall", 32'(p1_gnt_o), 32'h0);
            nxt();
        end
        mem_gnt_i = 1;
        mid();
        chk("st_p1_gnt", 32'(p1_gnt_o), 32'h1);
        chk("st_p0_gnt", 32'(p0_gnt_o), 32'h0);
        nxt();
        p1_req_i = 0; p1_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        mem_rdata_i = 32'h55AA55AA;
        mid();
        chk("st_p1_rv", 32'(p1_rvalid_o), 32'h1);
        chk("st_p0_rv", 32'(p0_rvalid_o), 32'h0);
        nxt();
        mem_rvalid_i = 0;

        // p0 memory stall of 5 cycles
        p0_req_i = 1; p0_we_i = 1; p0_addr_i = 32'h40;
        p0_wdata_i = 32'hA5A5A5A5; p0_be_i = 4'hc;
        nxt();
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("stall_mreq", 32'(mem_req_o), 32'h1);
            chk("stall_addr", mem_addr_o, 32'h40);
            chk("stall_wdata", mem_wdata_o, 32'hA5A5A5A5);
            chk("stall_be", 32'(mem_be_o), 32'hc);
            chk("stall_p0_gnt", 32'(p0_gnt_o), 32'h0);
            nxt();
        end
        mem_gnt_i = 1;
        mid();
        chk("stall_p0_gnt_rise", 32'(p0_gnt_o), 32'h1);
        nxt();
        p0_req_i = 0; p0_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        mid();
        chk("stall_p0_rv", 32'(p0_rvalid_o), 32'h1);
        nxt();
        mem_rvalid_i = 0;

        // starvation bound: both request continuously
        p0_req_i = 1; p0_addr_i = 32'h100; p0_be_i = 4'hf;
        p1_req_i = 1; p1_addr_i = 32'h200; p1_be_i = 4'hf;
        mem_gnt_i = 1; mem_rvalid_i = 1;
        for (int i = 0; i < 10; i++) begin
            nxt();
            mid();
            chk("arb_p0_gnt", 32'(p0_gnt_o), 32'(!exp_own[i]));
            chk("arb_p1_gnt", 32'(p1_gnt_o), 32'(exp_own[i]));
            chk("arb_addr", mem_addr_o,
                exp_own[i] ? 32'h200 : 32'h100);
            nxt();
            mid();
            chk("arb_p1_rv", 32'(p1_rvalid_o), 32'(exp_own[i]));
            nxt();
        end
        p0_req_i = 0; p1_req_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0;
        mid();
        chk("arb_end_busy", 32'(busy_o), 32'h0);

        // response timeout
        nxt();
        p0_req_i = 1; p0_addr_i = 32'hC;
        nxt();
        mem_gnt_i = 1;
        mid();
        chk("tmo_p0_gnt", 32'(p0_gnt_o), 32'h1);
        nxt();
        p0_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hFFFFFFFF;
        for (int k = 1; k < 16; k++) begin
            mid();
            chk("tmo_wait_rv", 32'(p0_rvalid_o), 32'h0);
            chk("tmo_wait_busy", 32'(busy_o), 32'h1);
            nxt();
        end
        mid();
        chk("tmo_rv", 32'(p0_rvalid_o), 32'h1);
        chk("tmo_err", 32'(p0_err_o), 32'h1);
        chk("tmo_rdata", p0_rdata_o, 32'h0);
        chk("tmo_p1_err", 32'(p1_err_o), 32'h0);
        nxt();
        mid();
        chk("tmo_busy_fall", 32'(busy_o), 32'h0);
        chk("tmo_err_gone", 32'(p0_err_o), 32'h0);

        // next access after timeout proceeds normally
        nxt();
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 32'h20;
        nxt();
        mem_gnt_i = 1;
        mid();
        chk("post_p1_gnt", 32'(p1_gnt_o), 32'h1);
        nxt();
        p1_req_i = 0; mem_gnt_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        mid();
        chk("post_p1_rv", 32'(p1_rvalid_o), 32'h1);
        chk("post_p1_rdata", p1_rdata_o, 32'hCAFEF00D);
        chk("post_p1_err", 32'(p1_err_o), 32'h0);
        nxt();
        mem_rvalid_i = 0;

        // reset while in RESP
        p0_req_i = 1; p0_addr_i = 32'h30;
        nxt();
        mem_gnt_i = 1;
        nxt();
        p0_req_i = 0; mem_gnt_i = 0;
        mid();
        chk("mrst_pre_busy", 32'(busy_o), 32'h1);
        nxt();
        rst_ni = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11111111;
        #1;
        chk("mrst_busy", 32'(busy_o), 32'h0);
        chk("mrst_addr", mem_addr_o, 32'h0);
        chk_quiet("mrst");
        #1;
        rst_ni = 1;
        mid();
        chk("late_rv_p0", 32'(p0_rvalid_o), 32'h0);
        chk("late_rdata_p0", p0_rdata_o, 32'h0);
        chk("late_busy", 32'(busy_o), 32'h0);
        nxt();
        mid();
        chk("late_rv_p0_2", 32'(p0_rvalid_o), 32'h0);
        mem_rvalid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
